// File: rtl/sbox_block_seq.sv
// sbox_block_seq: multi-cycle AES byte-substitution engine.
// A WIDTH-bit state word is latched on accept, then LANES bytes per cycle are
// run through the forward or inverse S-box and written back in place. After
// BEATS beats the finished word is presented on out_data until it is accepted.
// WIDTH must be a multiple of 8*LANES, and LANES one of 1, 2, 4, 8, 16.

module sbox_block_seq #(
    parameter int WIDTH = 128,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_inv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int BEATS = WIDTH / (8 * LANES);
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             armed;      // low during reset and until the first edge after release
    logic [CW-1:0]    beat;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_nxt;
    logic             inv_q;
    logic             accept;
    logic             last_beat;

    logic [7:0] lane_in  [LANES];
    logic [7:0] lane_fwd [LANES];
    logic [7:0] lane_inv [LANES];

    // GF(2^8) multiply modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    // Forward S-box: inverse followed by the affine map (rotations 1..4, xor 0x63).
    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Inverse S-box: inverse affine map (rotations 1, 3, 6, xor 0x05) then inverse.
    function automatic logic [7:0] sbox_inv(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    assign accept    = in_valid && in_ready;
    assign last_beat = (state == BUSY) && (beat == LAST_BEAT);

    // State register and the post-reset arm flag that gates in_ready.
    // NOTE: clocked blocks use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
        end
    end

    // Next-state logic: accept, walk the beats, wait for the consumer.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = BUSY;
            BUSY:    if (last_beat) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    in_ready  = armed;
            BUSY:    busy      = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Pick out the LANES bytes addressed by the current beat.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            lane_in[j] = work[(int'(beat) * LANES + j) * 8 +: 8];
        end
    end

    // One forward and one inverse S-box per lane; the latched mode picks later.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign lane_fwd[j] = sbox_fwd(lane_in[j]);
        assign lane_inv[j] = sbox_inv(lane_in[j]);
    end

    // Work word with this beat's substituted bytes written back in place.
    always_comb begin
        work_nxt = work;
        for (int j = 0; j < LANES; j++) begin
            work_nxt[(int'(beat) * LANES + j) * 8 +: 8] = inv_q ? lane_inv[j] : lane_fwd[j];
        end
    end

    // Beat counter and result register; both clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat     <= '0;
            out_data <= '0;
        end else begin
            if (accept) begin
                beat <= '0;
            end else if ((state == BUSY) && !last_beat) begin
                beat <= beat + 1'b1;
            end
            if (last_beat) begin
                out_data <= work_nxt;
            end
        end
    end

    // Work register and latched mode, loaded on accept and updated each beat.
    // NOTE: no reset here; these are only read after an accept has loaded them.
    always_ff @(posedge clk) begin
        if (accept) begin
            work  <= in_data;
            inv_q <= in_inv;
        end else if (state == BUSY) begin
            work  <= work_nxt;
        end
    end

endmodule

// File: tb/tb_sbox_block_seq.sv
// Testbench for sbox_block_seq. Three instances (LANES = 4, 16, 1 at WIDTH=128)
// share the same input stimulus; each is checked against S-box tables built
// here from first principles (brute-force field inverse plus the affine map).

module tb_sbox_block_seq;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] in_data;
    logic         in_inv;
    logic         out_ready;

    logic [2:0]   in_ready_a;
    logic [2:0]   out_valid_a;
    logic [2:0]   busy_a;
    logic [127:0] out_data_a [3];

    int           exp_lat [3];
    int           n_checks = 0;
    int           n_pass   = 0;

    logic [7:0]   fwd_tab [256];
    logic [7:0]   inv_tab [256];

    sbox_block_seq #(.WIDTH(128), .LANES(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_a[0]), .in_data(in_data), .in_inv(in_inv),
        .out_valid(out_valid_a[0]), .out_ready(out_ready), .out_data(out_data_a[0]),
        .busy(busy_a[0])
    );

    sbox_block_seq #(.WIDTH(128), .LANES(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_a[1]), .in_data(in_data), .in_inv(in_inv),
        .out_valid(out_valid_a[1]), .out_ready(out_ready), .out_data(out_data_a[1]),
        .busy(busy_a[1])
    );

    sbox_block_seq #(.WIDTH(128), .LANES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_a[2]), .in_data(in_data), .in_inv(in_inv),
        .out_valid(out_valid_a[2]), .out_ready(out_ready), .out_data(out_data_a[2]),
        .busy(busy_a[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Polynomial product reduced by long division modulo 0x11b.
    function automatic logic [7:0] poly_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) prod = prod ^ (16'(a) << i);
        end
        for (int i = 15; i >= 8; i--) begin
            if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
        end
        return prod[7:0];
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && poly_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                     ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            end
            fwd_tab[x] = s;
            inv_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model_word(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) begin
            r[8*b +: 8] = inv ? inv_tab[d[8*b +: 8]] : fwd_tab[d[8*b +: 8]];
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One word through all instances with out_ready high; checks latency,
    // result, and the return to IDLE one cycle after each output handshake.
    task automatic run_word(input logic [127:0] data, input logic inv,
                            input logic [127:0] exp, input bit wiggle, input string tag);
        bit [2:0] pend;
        bit [2:0] fin;
        int       k;
        pend = '0;
        fin  = '0;
        @(negedge clk);
        in_data   = data;
        in_inv    = inv;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        k = 0;
        while (in_ready_a != 3'b111 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (in_ready_a != 3'b111) begin
            check({tag, " in_ready wait"}, in_ready_a, 3'b111);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, " busy after accept"}, busy_a, 3'b111);
        check({tag, " in_ready after accept"}, in_ready_a, 3'b000);
        k = 0;
        while (fin != 3'b111 && k < 40) begin
            for (int i = 0; i < 3; i++) begin
                if (pend[i]) begin
                    check($sformatf("%s i%0d in_ready after hs", tag, i), in_ready_a[i], 1'b1);
                    check($sformatf("%s i%0d out_valid after hs", tag, i), out_valid_a[i], 1'b0);
                    check($sformatf("%s i%0d data held", tag, i), out_data_a[i], exp);
                    pend[i] = 1'b0;
                    fin[i]  = 1'b1;
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (!fin[i] && !pend[i] && out_valid_a[i]) begin
                    check($sformatf("%s i%0d latency", tag, i), 128'(k + 1), 128'(exp_lat[i]));
                    check($sformatf("%s i%0d data", tag, i), out_data_a[i], exp);
                    pend[i] = 1'b1;
                end
            end
            if (wiggle) begin
                in_inv  = ~in_inv;
                in_data = rand128();
            end
            if (fin != 3'b111) begin
                @(negedge clk);
                k++;
            end
        end
        if (fin != 3'b111) check({tag, " completion timeout"}, fin, 3'b111);
    endtask

    initial begin
        logic [127:0] vec_in;
        logic [127:0] vec_out;
        logic [127:0] d;
        logic [127:0] exp;
        logic         m;
        int           k;

        exp_lat[0] = 128 / (8 * 4) + 1;
        exp_lat[1] = 128 / (8 * 16) + 1;
        exp_lat[2] = 128 / (8 * 1) + 1;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_inv    = 1'b0;
        out_ready = 1'b0;
        build_tables();

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset i%0d in_ready", i), in_ready_a[i], 1'b0);
            check($sformatf("reset i%0d out_valid", i), out_valid_a[i], 1'b0);
            check($sformatf("reset i%0d busy", i), busy_a[i], 1'b0);
            check($sformatf("reset i%0d out_data", i), out_data_a[i], '0);
        end
        rst_n = 1'b1;
        #1 check("in_ready before first edge", in_ready_a, 3'b000);
        @(negedge clk);
        check("in_ready after release", in_ready_a, 3'b111);

        // Scenario 1: all-zero word forward
        run_word('0, 1'b0, {16{8'h63}}, 1'b0, "zero fwd");

        // Scenario 2: byte positions, forward then back through the inverse
        vec_in  = 128'h000102030405060708090A0B0C0D0E0F;
        vec_out = 128'h637C777BF26B6FC53001672BFED7AB76;
        run_word(vec_in, 1'b0, vec_out, 1'b0, "bytepos fwd");
        run_word(vec_out, 1'b1, vec_in, 1'b0, "bytepos inv");

        // Scenario 3: backpressure
        d   = rand128();
        exp = model_word(d, 1'b0);
        @(negedge clk);
        in_data = d; in_inv = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (out_valid_a != 3'b111 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("bp all out_valid", out_valid_a, 3'b111);
        in_valid = 1'b1;
        in_data  = rand128();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("bp c%0d i%0d out_data", c, i), out_data_a[i], exp);
                check($sformatf("bp c%0d i%0d in_ready", c, i), in_ready_a[i], 1'b0);
                check($sformatf("bp c%0d i%0d out_valid", c, i), out_valid_a[i], 1'b1);
            end
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        check("bp release out_valid", out_valid_a, 3'b000);
        check("bp release in_ready", in_ready_a, 3'b111);
        check("bp release data held", out_data_a[0], exp);
        @(negedge clk);
        check("bp no second hs out_valid", out_valid_a, 3'b000);
        check("bp nothing queued busy", busy_a, 3'b000);

        // Scenario 4: mode latched at accept, in_inv toggled during BUSY
        run_word({16{8'h53}}, 1'b0, {16{8'hED}}, 1'b1, "mode latch");

        // Scenario 5: reset part-way through a word
        @(negedge clk);
        in_data = rand128(); in_inv = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("midbusy i0 busy before reset", busy_a[0], 1'b1);
        rst_n = 1'b0;
        #1;
        check("midbusy reset out_valid", out_valid_a, 3'b000);
        check("midbusy reset busy", busy_a, 3'b000);
        check("midbusy reset in_ready", in_ready_a, 3'b000);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("midbusy reset i%0d out_data", i), out_data_a[i], '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midbusy release in_ready", in_ready_a, 3'b111);
        check("midbusy release out_valid", out_valid_a, 3'b000);
        check("midbusy release out_data", out_data_a[0], '0);
        d = rand128();
        run_word(d, 1'b0, model_word(d, 1'b0), 1'b0, "after reset");

        // Randomised words in both directions
        for (int n = 0; n < 8; n++) begin
            d = rand128();
            m = 1'($urandom_range(0, 1));
            run_word(d, m, model_word(d, m), 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
